// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-op codes, FSM states,
// and helpers for lane selection and alignment checks.
package cpu_pkg;

  localparam int MEM_OP_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  // Byte lanes touched by an access; loads and stores share the same lane rule.
  function automatic logic [3:0] lane_mask(input logic [MEM_OP_W-1:0] op,
                                           input logic [1:0] a);
    logic [3:0] be;
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: be = 4'b0001 << a;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
      default:                          be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [MEM_OP_W-1:0] op,
                                              input logic [31:0] d);
    logic [31:0] w;
    case (op)
      MEM_OP_SB: w = {4{d[7:0]}};
      MEM_OP_SH: w = {2{d[15:0]}};
      MEM_OP_SW: w = d;
      default:   w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic misaligned(input logic [MEM_OP_W-1:0] op,
                                      input logic [1:0] a);
    logic bad;
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: bad = a[0];
      MEM_OP_LW, MEM_OP_SW:             bad = (a != 2'b00);
      default:                          bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks the addressed byte/half from the read
// word and sign- or zero-extends it according to the load op.
module mem_load_align
  import cpu_pkg::*;
(
  input  logic [31:0]         rdata,
  input  logic [1:0]          lane,
  input  logic [MEM_OP_W-1:0] op,
  output logic [31:0]         result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h0;
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  always_comb begin
    result = rdata;
    case (op)
      MEM_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: result = {24'h0, byte_sel};
      MEM_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: result = {16'h0, half_sel};
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one data-RAM access per instruction over req/ack, with
// timeout abort and register write-back. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_alu_res,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rf_waddr,
  input  logic              ex_rf_wen,
  output logic              dram_req,
  output logic              dram_we,
  output logic [3:0]        dram_be,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [31:0]       dram_wdata,
  input  logic              dram_ack,
  input  logic [31:0]       dram_rdata,
  output logic              wb_valid,
  output logic              wb_rf_wen,
  output logic [4:0]        wb_rf_waddr,
  output logic [31:0]       wb_rf_wdata,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e          state, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [MEM_OP_W-1:0] op_q;
  logic [1:0]          lane_q;
  logic [4:0]          waddr_q;
  logic                wen_q;
  logic [31:0]         load_data;
  logic                ex_is_mem;
  logic                ex_misalign;
  logic                timeout;

  assign ex_is_mem = is_load(ex_mem_op) || is_store(ex_mem_op);

`ifdef MEM_ALIGN_CHECK_EN
  assign ex_misalign = ex_is_mem && misaligned(ex_mem_op, ex_alu_res[1:0]);
`else
  assign ex_misalign = 1'b0;
`endif

  assign timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ex_ready = (state == ST_IDLE);
  // Derived from the state register so an async reset drops the request at once.
  assign dram_req = (state == ST_ACCESS);

  mem_load_align u_load_align (
    .rdata  (dram_rdata),
    .lane   (lane_q),
    .op     (op_q),
    .result (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (ex_valid && ex_is_mem && !ex_misalign) state_d = ST_ACCESS;
      ST_ACCESS: if (dram_ack || timeout) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured once at issue and held stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      op_q        <= MEM_OP_NONE;
      lane_q      <= 2'b00;
      waddr_q     <= 5'd0;
      wen_q       <= 1'b0;
      dram_we     <= 1'b0;
      dram_be     <= 4'b0000;
      dram_addr   <= '0;
      dram_wdata  <= 32'h0;
      wb_valid    <= 1'b0;
      wb_rf_wen   <= 1'b0;
      wb_rf_waddr <= 5'd0;
      wb_rf_wdata <= 32'h0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!ex_is_mem) begin
              wb_valid    <= 1'b1;
              wb_rf_wen   <= ex_rf_wen;
              wb_rf_waddr <= ex_rf_waddr;
              wb_rf_wdata <= ex_alu_res;
            end else if (ex_misalign) begin
              wb_valid    <= 1'b1;
              wb_rf_wen   <= 1'b0;
              wb_rf_waddr <= ex_rf_waddr;
              wb_rf_wdata <= 32'h0;
              mem_err     <= 1'b1;
            end else begin
              cnt        <= '0;
              op_q       <= ex_mem_op;
              lane_q     <= ex_alu_res[1:0];
              waddr_q    <= ex_rf_waddr;
              wen_q      <= ex_rf_wen;
              dram_we    <= is_store(ex_mem_op);
              dram_be    <= lane_mask(ex_mem_op, ex_alu_res[1:0]);
              dram_addr  <= {ex_alu_res[ADDR_W-1:2], 2'b00};
              dram_wdata <= store_lanes(ex_mem_op, ex_store_data);
            end
          end
        end
        ST_ACCESS: begin
          if (dram_ack) begin
            wb_valid    <= 1'b1;
            wb_rf_waddr <= waddr_q;
            wb_rf_wen   <= is_load(op_q) ? wen_q : 1'b0;
            wb_rf_wdata <= is_load(op_q) ? load_data : 32'h0;
          end else if (timeout) begin
            wb_valid    <= 1'b1;
            wb_rf_wen   <= 1'b0;
            wb_rf_waddr <= waddr_q;
            wb_rf_wdata <= 32'h0;
            mem_err     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: stores, aligned/unaligned
// loads, NONE streaming, timeout abort and reset during an access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rf_waddr;
  logic        ex_rf_wen;
  logic        dram_req;
  logic        dram_we;
  logic [3:0]  dram_be;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;
  logic        wb_valid;
  logic        wb_rf_wen;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_op     (ex_mem_op),
    .ex_alu_res    (ex_alu_res),
    .ex_store_data (ex_store_data),
    .ex_rf_waddr   (ex_rf_waddr),
    .ex_rf_wen     (ex_rf_wen),
    .dram_req      (dram_req),
    .dram_we       (dram_we),
    .dram_be       (dram_be),
    .dram_addr     (dram_addr),
    .dram_wdata    (dram_wdata),
    .dram_ack      (dram_ack),
    .dram_rdata    (dram_rdata),
    .wb_valid      (wb_valid),
    .wb_rf_wen     (wb_rf_wen),
    .wb_rf_waddr   (wb_rf_waddr),
    .wb_rf_wdata   (wb_rf_wdata),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] wa, input logic we);
    ex_valid      = v;
    ex_mem_op     = op;
    ex_alu_res    = alu;
    ex_store_data = sd;
    ex_rf_waddr   = wa;
    ex_rf_wen     = we;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues a load, acks in the first access cycle and checks the written-back value.
  task automatic loadImmediate(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] rd, input logic [3:0] exp_be,
                               input logic [31:0] exp_data);
    applyStimulus(1'b1, op, a, 32'h0, 5'd7, 1'b1);
    tick();
    ex_valid = 1'b0;
    checkOutput({tag, "_req"}, 32'(dram_req), 32'd1);
    checkOutput({tag, "_be"}, 32'(dram_be), 32'(exp_be));
    dram_ack   = 1'b1;
    dram_rdata = rd;
    tick();
    dram_ack = 1'b0;
    checkOutput({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    checkOutput({tag, "_wen"}, 32'(wb_rf_wen), 32'd1);
    checkOutput({tag, "_waddr"}, 32'(wb_rf_waddr), 32'd7);
    checkOutput({tag, "_wdata"}, wb_rf_wdata, exp_data);
  endtask

  task automatic storeImmediate(input string tag, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata);
    applyStimulus(1'b1, op, a, d, 5'd3, 1'b1);
    tick();
    ex_valid = 1'b0;
    checkOutput({tag, "_we"}, 32'(dram_we), 32'd1);
    checkOutput({tag, "_be"}, 32'(dram_be), 32'(exp_be));
    checkOutput({tag, "_wdata"}, dram_wdata, exp_wdata);
    dram_ack = 1'b1;
    tick();
    dram_ack = 1'b0;
    checkOutput({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    checkOutput({tag, "_wen"}, 32'(wb_rf_wen), 32'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    dram_ack   = 1'b0;
    dram_rdata = 32'h0;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_ready", 32'(ex_ready), 32'd1);
    checkOutput("rst_req", 32'(dram_req), 32'd0);
    checkOutput("rst_wbv", 32'(wb_valid), 32'd0);
    checkOutput("rst_be", 32'(dram_be), 32'd0);
    checkOutput("rst_err", 32'(mem_err), 32'd0);
    reset = 1'b0;
    tick();

    // SW with ack two cycles after the request rises.
    applyStimulus(1'b1, OP_SW, 32'h100, 32'hDEADBEEF, 5'd3, 1'b0);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw_req", 32'(dram_req), 32'd1);
      checkOutput("sw_ready", 32'(ex_ready), 32'd0);
      checkOutput("sw_addr", dram_addr, 32'h100);
      checkOutput("sw_be", 32'(dram_be), 32'hF);
      checkOutput("sw_wdata", dram_wdata, 32'hDEADBEEF);
      checkOutput("sw_wbv_early", 32'(wb_valid), 32'd0);
      if (i == 2) dram_ack = 1'b1;
      tick();
    end
    dram_ack = 1'b0;
    checkOutput("sw_wbv", 32'(wb_valid), 32'd1);
    checkOutput("sw_wen", 32'(wb_rf_wen), 32'd0);
    checkOutput("sw_req_drop", 32'(dram_req), 32'd0);
    checkOutput("sw_ready_back", 32'(ex_ready), 32'd1);
    tick();
    checkOutput("sw_wbv_pulse", 32'(wb_valid), 32'd0);

    loadImmediate("lb", OP_LB, 32'h103, 32'h80FF1234, 4'b1000, 32'hFFFFFF80);
    loadImmediate("lbu", OP_LBU, 32'h103, 32'h80FF1234, 4'b1000, 32'h00000080);
    loadImmediate("lh", OP_LH, 32'h102, 32'h80FF1234, 4'b1100, 32'hFFFF80FF);

    storeImmediate("sh", OP_SH, 32'h102, 32'h0000ABCD, 4'b1100, 32'hABCDABCD);
    storeImmediate("sb", OP_SB, 32'h101, 32'h0000005A, 4'b0010, 32'h5A5A5A5A);
    tick();

    // NONE ops stream one per cycle without touching the RAM.
    applyStimulus(1'b1, OP_NONE, 32'h12345678, 32'h0, 5'd5, 1'b1);
    tick();
    checkOutput("none1_wbv", 32'(wb_valid), 32'd1);
    checkOutput("none1_wdata", wb_rf_wdata, 32'h12345678);
    checkOutput("none1_waddr", 32'(wb_rf_waddr), 32'd5);
    checkOutput("none1_req", 32'(dram_req), 32'd0);
    checkOutput("none1_ready", 32'(ex_ready), 32'd1);
    applyStimulus(1'b1, 4'd12, 32'h9, 32'h0, 5'd6, 1'b1);
    tick();
    ex_valid = 1'b0;
    checkOutput("none2_wbv", 32'(wb_valid), 32'd1);
    checkOutput("none2_wdata", wb_rf_wdata, 32'h9);
    checkOutput("none2_waddr", 32'(wb_rf_waddr), 32'd6);
    checkOutput("none2_wen", 32'(wb_rf_wen), 32'd1);
    checkOutput("none2_req", 32'(dram_req), 32'd0);
    checkOutput("none2_ready", 32'(ex_ready), 32'd1);
    tick();
    checkOutput("none_wbv_end", 32'(wb_valid), 32'd0);

    // LW with ack withheld: request stays up for exactly 64 cycles.
    applyStimulus(1'b1, OP_LW, 32'h200, 32'h0, 5'd9, 1'b1);
    tick();
    ex_valid = 1'b0;
    n = 0;
    while (dram_req && n < 100) begin
      n++;
      tick();
    end
    checkOutput("to_cycles", 32'(n), 32'd64);
    checkOutput("to_wbv", 32'(wb_valid), 32'd1);
    checkOutput("to_err", 32'(mem_err), 32'd1);
    checkOutput("to_wen", 32'(wb_rf_wen), 32'd0);
    dram_ack = 1'b1;
    tick();
    dram_ack = 1'b0;
    checkOutput("late_ack_wbv", 32'(wb_valid), 32'd0);
    checkOutput("late_ack_err", 32'(mem_err), 32'd0);
    checkOutput("late_ack_ready", 32'(ex_ready), 32'd1);

    // Reset in the middle of an access.
    applyStimulus(1'b1, OP_LW, 32'h300, 32'h0, 5'd10, 1'b1);
    tick();
    ex_valid = 1'b0;
    tick();
    checkOutput("rmid_req_before", 32'(dram_req), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rmid_req_drop", 32'(dram_req), 32'd0);
    tick();
    checkOutput("rmid_wbv", 32'(wb_valid), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rmid_wbv_after", 32'(wb_valid), 32'd0);
    checkOutput("rmid_ready", 32'(ex_ready), 32'd1);

    // Unaligned LW.
    applyStimulus(1'b1, OP_LW, 32'h101, 32'h0, 5'd11, 1'b1);
    tick();
    ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("mis_req", 32'(dram_req), 32'd0);
    checkOutput("mis_wbv", 32'(wb_valid), 32'd1);
    checkOutput("mis_err", 32'(mem_err), 32'd1);
    checkOutput("mis_wen", 32'(wb_rf_wen), 32'd0);
    checkOutput("mis_ready", 32'(ex_ready), 32'd1);
`else
    checkOutput("mis_req", 32'(dram_req), 32'd1);
    checkOutput("mis_addr", dram_addr, 32'h100);
    checkOutput("mis_be", 32'(dram_be), 32'hF);
    dram_ack   = 1'b1;
    dram_rdata = 32'h11223344;
    tick();
    dram_ack = 1'b0;
    checkOutput("mis_wbv", 32'(wb_valid), 32'd1);
    checkOutput("mis_wdata", wb_rf_wdata, 32'h11223344);
    checkOutput("mis_err", 32'(mem_err), 32'd0);
    checkOutput("mis_wen", 32'(wb_rf_wen), 32'd1);
    checkOutput("mis_waddr", 32'(wb_rf_waddr), 32'd11);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
